// File: rtl/bubble_pkg.sv
// ============================================================================
// bubble_pkg: shared types and constants for bubble_sort_ctrl.   Rev 1.0
// ============================================================================
`default_nettype none

package bubble_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] MUX_SEL_ZERO = 2'd0;
  localparam logic [1:0] MUX_SEL_ALU  = 2'd1;
  localparam logic       ALU_SRC_I    = 1'b0;
  localparam logic       ALU_SRC_J    = 1'b1;
  localparam logic       WSEL_A       = 1'b0;
  localparam logic       WSEL_B       = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT_I = 4'd1,
    S_INIT_J = 4'd2,
    S_CHK_J  = 4'd3,
    S_RD_A   = 4'd4,
    S_LD_A   = 4'd5,
    S_RD_B   = 4'd6,
    S_LD_B   = 4'd7,
    S_CMP    = 4'd8,
    S_WR_A   = 4'd9,
    S_WR_B   = 4'd10,
    S_INC_J  = 4'd11,
    S_INC_I  = 4'd12,
    S_CHK_I  = 4'd13,
    S_DONE   = 4'd14
  } state_t;

  typedef struct packed {
    logic [1:0] mux_sel_i;
    logic [1:0] mux_sel_j;
    logic       load_i;
    logic       load_j;
    logic       load_k;
    logic       load_A;
    logic       load_B;
    logic       alu_src;
    logic       mem_re;
    logic       mem_we;
    logic       mem_wsel;
    logic       busy;
    logic       done;
  } ctrl_t;

  function automatic ctrl_t decode(state_t s);
    ctrl_t c = '0;
    c.busy = (s != S_IDLE) && (s != S_DONE);
    case (s)
      S_INIT_I: begin c.load_i = 1'b1; c.mux_sel_i = MUX_SEL_ZERO; end
      S_INIT_J: begin c.load_j = 1'b1; c.mux_sel_j = MUX_SEL_ZERO; end
      S_RD_A:   begin c.mem_re = 1'b1; c.load_k = 1'b1; c.alu_src = ALU_SRC_J; end
      S_LD_A:   c.load_A = 1'b1;
      S_RD_B:   c.mem_re = 1'b1;
      S_LD_B:   c.load_B = 1'b1;
      S_WR_A:   begin c.mem_we = 1'b1; c.mem_wsel = WSEL_B; end
      S_WR_B:   begin c.mem_we = 1'b1; c.mem_wsel = WSEL_A; end
      S_INC_J:  begin c.load_j = 1'b1; c.mux_sel_j = MUX_SEL_ALU; c.alu_src = ALU_SRC_J; end
      S_INC_I:  begin c.load_i = 1'b1; c.mux_sel_i = MUX_SEL_ALU; c.alu_src = ALU_SRC_I; end
      S_DONE:   c.done = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bubble_sort_ctrl_if.sv
// ============================================================================
// bubble_sort_ctrl_if: controller <-> register file / memory bundle.   Rev 1.0
// ============================================================================
`default_nettype none

interface bubble_sort_ctrl_if import bubble_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              start;
  logic [ADDR_W-1:0] n;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] k;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [1:0]        mux_sel_i;
  logic [1:0]        mux_sel_j;
  logic              mux_sel_k;
  logic              load_i;
  logic              load_j;
  logic              load_k;
  logic              load_A;
  logic              load_B;
  logic              alu_src;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic              mem_wsel;
  logic              busy;
  logic              done;

  modport master (
    input  start, n, i, j, k, A, B,
    output mux_sel_i, mux_sel_j, mux_sel_k, load_i, load_j, load_k, load_A, load_B,
           alu_src, mem_addr, mem_re, mem_we, mem_wsel, busy, done
  );

  modport slave (
    output start, n, i, j, k, A, B,
    input  mux_sel_i, mux_sel_j, mux_sel_k, load_i, load_j, load_k, load_A, load_B,
           alu_src, mem_addr, mem_re, mem_we, mem_wsel, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/bubble_cmp.sv
// ============================================================================
// bubble_cmp: unsigned strict greater-than compare of A and B.   Rev 1.0
// ============================================================================
`default_nettype none

module bubble_cmp #(
  parameter int DATA_W = 16
) (
  input  wire logic [DATA_W-1:0] a,
  input  wire logic [DATA_W-1:0] b,
  output logic                   gt
);
  assign gt = (a > b);
endmodule

`default_nettype wire

// File: rtl/bubble_sort_ctrl.sv
// ============================================================================
// bubble_sort_ctrl: bubble-sort sequencer, optional BUBBLE_EARLY_EXIT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module bubble_sort_ctrl import bubble_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  bubble_sort_ctrl_if.master bus
);

  state_t            state;
  state_t            state_nxt;
  ctrl_t             ctrl;
  ctrl_t             ctrl_nxt;
  logic [ADDR_W-1:0] n_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [ADDR_W-1:0] pass_lim;
  logic              a_gt_b;
`ifdef BUBBLE_EARLY_EXIT_EN
  logic              swapped;
`endif

  bubble_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a  (bus.A),
    .b  (bus.B),
    .gt (a_gt_b)
  );

  // Cannot underflow: CHK_J is only reached while i < n_r-1.
  assign pass_lim = n_r - ADDR_W'(1) - bus.i;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = (bus.n >= ADDR_W'(2)) ? S_INIT_I : S_DONE;
      S_INIT_I: state_nxt = S_INIT_J;
      S_INIT_J: state_nxt = S_CHK_J;
      S_CHK_J:  state_nxt = (bus.j >= pass_lim) ? S_INC_I : S_RD_A;
      S_RD_A:   state_nxt = S_LD_A;
      S_LD_A:   state_nxt = S_RD_B;
      S_RD_B:   state_nxt = S_LD_B;
      S_LD_B:   state_nxt = S_CMP;
      S_CMP:    state_nxt = a_gt_b ? S_WR_A : S_INC_J;
      S_WR_A:   state_nxt = S_WR_B;
      S_WR_B:   state_nxt = S_INC_J;
      S_INC_J:  state_nxt = S_CHK_J;
`ifdef BUBBLE_EARLY_EXIT_EN
      S_INC_I:  state_nxt = swapped ? S_CHK_I : S_DONE;
`else
      S_INC_I:  state_nxt = S_CHK_I;
`endif
      S_CHK_I:  state_nxt = (bus.i >= n_r - ADDR_W'(1)) ? S_DONE : S_INIT_J;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    ctrl_nxt = decode(state_nxt);
`ifdef BUBBLE_EARLY_EXIT_EN
    if (state_nxt == S_INC_I && !swapped) begin
      ctrl_nxt.load_i    = 1'b0;
      ctrl_nxt.mux_sel_i = MUX_SEL_ZERO;
      ctrl_nxt.alu_src   = 1'b0;
    end
`endif
    mem_addr_nxt = '0;
    case (state_nxt)
      S_RD_A, S_WR_A: mem_addr_nxt = bus.j;
      S_RD_B, S_WR_B: mem_addr_nxt = bus.k;
      default:        mem_addr_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ctrl       <= '0;
      mem_addr_r <= '0;
      n_r        <= '0;
`ifdef BUBBLE_EARLY_EXIT_EN
      swapped    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      ctrl       <= ctrl_nxt;
      mem_addr_r <= mem_addr_nxt;
      if (state == S_IDLE && bus.start && bus.n >= ADDR_W'(2))
        n_r <= bus.n;
`ifdef BUBBLE_EARLY_EXIT_EN
      if (state == S_INIT_J)
        swapped <= 1'b0;
      else if (state == S_WR_A)
        swapped <= 1'b1;
`endif
    end
  end

  assign bus.mux_sel_i = ctrl.mux_sel_i;
  assign bus.mux_sel_j = ctrl.mux_sel_j;
  assign bus.mux_sel_k = 1'b0;
  assign bus.load_i    = ctrl.load_i;
  assign bus.load_j    = ctrl.load_j;
  assign bus.load_k    = ctrl.load_k;
  assign bus.load_A    = ctrl.load_A;
  assign bus.load_B    = ctrl.load_B;
  assign bus.alu_src   = ctrl.alu_src;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_re    = ctrl.mem_re;
  assign bus.mem_we    = ctrl.mem_we;
  assign bus.mem_wsel  = ctrl.mem_wsel;
  assign bus.busy      = ctrl.busy;
  assign bus.done      = ctrl.done;

endmodule

`default_nettype wire

// File: tb/tb_bubble_sort_ctrl.sv
// ============================================================================
// tb_bubble_sort_ctrl: randomized self-checking bench for bubble_sort_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bubble_sort_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bubble_sort_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bubble_sort_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int fails  = 0;

  // Environment: register file, ALU and memory steered by the controller.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] init_mem [0:15];
  logic [DW-1:0] exp_mem  [0:15];
  logic          preload = 1'b0;
  logic [AW-1:0] ri, rj, rk, alu;
  logic [DW-1:0] rA, rB, rdata;

  assign alu   = (bus.alu_src ? rj : ri) + 10'd1;
  assign bus.i = ri;
  assign bus.j = rj;
  assign bus.k = rk;
  assign bus.A = rA;
  assign bus.B = rB;

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 16; a++) mem[a] <= init_mem[a];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wsel ? rB : rA;
    end
    if (bus.load_i) ri <= (bus.mux_sel_i == 2'd0) ? '0 : alu;
    if (bus.load_j) rj <= (bus.mux_sel_j == 2'd0) ? '0 : alu;
    if (bus.load_k) rk <= alu;
    if (bus.mem_re) rdata <= mem[bus.mem_addr];
    if (bus.load_A) rA <= rdata;
    if (bus.load_B) rB <= rdata;
  end

  int done_cnt, busy_done, we_cnt, re_cnt, cmp_cnt;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.done && bus.busy) busy_done++;
      if (bus.mem_we) we_cnt++;
      if (bus.mem_re) re_cnt++;
      if (bus.load_B) cmp_cnt++;
    end
  end

  // Reference: textbook bubble sort over exp_mem, counting compares and swaps.
  int exp_cmps, exp_swaps;
  task automatic model_sort(input int nn);
    logic [DW-1:0] t;
    bit sw;
    exp_cmps  = 0;
    exp_swaps = 0;
    for (int p = 0; p < nn - 1; p++) begin
      sw = 1'b0;
      for (int q = 0; q < nn - 1 - p; q++) begin
        exp_cmps++;
        if (exp_mem[q] > exp_mem[q+1]) begin
          t = exp_mem[q]; exp_mem[q] = exp_mem[q+1]; exp_mem[q+1] = t;
          exp_swaps++;
          sw = 1'b1;
        end
      end
`ifdef BUBBLE_EARLY_EXIT_EN
      if (!sw) break;
`endif
    end
  endtask

  task automatic prep(input int nn);
    for (int a = 0; a < 16; a++) exp_mem[a] = init_mem[a];
    model_sort(nn);
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
  endtask

  task automatic run_sort(input int nn, input bit pulse_in_cmp, output bit got);
    int cyc;
    bit arm, pulsed;
    @(posedge clk);
    done_cnt = 0; busy_done = 0; we_cnt = 0; re_cnt = 0; cmp_cnt = 0;
    @(negedge clk); bus.n = nn[AW-1:0]; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.n = AW'($urandom);
    got = 1'b0; cyc = 0; pulsed = 1'b0;
    while (!got && cyc < LIMIT) begin
      if (bus.done) got = 1'b1;
      else begin
        arm = pulse_in_cmp && bus.load_B && !pulsed;
        @(negedge clk); cyc++;
        bus.start = arm;
        if (arm) pulsed = 1'b1;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (!got) begin fails++; $display("FAIL done_timeout n=%0d: done not seen in %0d cycles", nn, LIMIT); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.n = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.mem_re, bus.mem_we} !== 4'b0) begin
      fails++; $display("FAIL reset_status got=%b want=0000", {bus.busy, bus.done, bus.mem_re, bus.mem_we});
    end
    checks++;
    if ({bus.load_i, bus.load_j, bus.load_k, bus.load_A, bus.load_B, bus.mux_sel_i, bus.mux_sel_j, bus.mem_addr} !== '0) begin
      fails++; $display("FAIL reset_ctrl got nonzero load/mux/addr");
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    bit got;
    init_mem[0] = 3; init_mem[1] = 1; init_mem[2] = 4; init_mem[3] = 2;
    prep(4);
    run_sort(4, 1'b0, got);
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (mem[a] !== DW'(a + 1)) begin fails++; $display("FAIL directed_mem[%0d] got=%0d want=%0d", a, mem[a], a + 1); end
    end
    checks++;
    if (done_cnt !== 1) begin fails++; $display("FAIL directed_done_cnt got=%0d want=1", done_cnt); end
    checks++;
    if (busy_done !== 0) begin fails++; $display("FAIL directed_busy_in_done got=%0d want=0", busy_done); end
  endtask

  task automatic test_n1();
    int cyc;
    bit got;
    @(posedge clk);
    done_cnt = 0; we_cnt = 0; re_cnt = 0;
    @(negedge clk); bus.n = 10'd1; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 4) begin
      if (bus.done) got = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    @(negedge clk);
    checks++;
    if (!got || cyc > 1) begin fails++; $display("FAIL n1_latency got_done=%0b extra_cycles=%0d want=1,<=1", got, cyc); end
    checks++;
    if (re_cnt + we_cnt !== 0) begin fails++; $display("FAIL n1_mem_access got=%0d want=0", re_cnt + we_cnt); end
  endtask

  task automatic test_sorted();
    bit got;
    init_mem[0] = 1; init_mem[1] = 2; init_mem[2] = 3; init_mem[3] = 4;
    prep(4);
    run_sort(4, 1'b0, got);
    checks++;
    if (cmp_cnt !== exp_cmps) begin fails++; $display("FAIL sorted_cmp_cnt got=%0d want=%0d", cmp_cnt, exp_cmps); end
    checks++;
    if (we_cnt !== 0) begin fails++; $display("FAIL sorted_writes got=%0d want=0", we_cnt); end
  endtask

  task automatic test_equal();
    bit got;
    init_mem[0] = 5; init_mem[1] = 5;
    prep(2);
    run_sort(2, 1'b0, got);
    checks++;
    if (we_cnt !== 0) begin fails++; $display("FAIL equal_writes got=%0d want=0", we_cnt); end
    checks++;
    if (mem[0] !== 16'd5 || mem[1] !== 16'd5) begin fails++; $display("FAIL equal_mem got=%0d,%0d want=5,5", mem[0], mem[1]); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit got;
    init_mem[0] = 4; init_mem[1] = 3; init_mem[2] = 2; init_mem[3] = 1;
    prep(4);
    @(negedge clk); bus.n = 10'd4; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 0;
    while (!(bus.mem_we && bus.mem_wsel) && cyc < LIMIT) begin @(negedge clk); cyc++; end
    checks++;
    if (!(bus.mem_we && bus.mem_wsel)) begin fails++; $display("FAIL midreset_no_wr_a got=0 want=1"); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_we, bus.busy} !== 2'b00) begin fails++; $display("FAIL midreset_outputs got=%b want=00", {bus.mem_we, bus.busy}); end
    rst_n = 1'b1;
    init_mem[0] = 6; init_mem[1] = 2; init_mem[2] = 9; init_mem[3] = 1; init_mem[4] = 5;
    prep(5);
    run_sort(5, 1'b0, got);
    for (int a = 0; a < 5; a++) begin
      checks++;
      if (mem[a] !== exp_mem[a]) begin fails++; $display("FAIL midreset_resort[%0d] got=%0d want=%0d", a, mem[a], exp_mem[a]); end
    end
  endtask

  task automatic test_start_in_cmp();
    bit got;
    init_mem[0] = 7; init_mem[1] = 3; init_mem[2] = 8; init_mem[3] = 3; init_mem[4] = 0; init_mem[5] = 2;
    prep(6);
    run_sort(6, 1'b1, got);
    for (int a = 0; a < 6; a++) begin
      checks++;
      if (mem[a] !== exp_mem[a]) begin fails++; $display("FAIL startcmp_mem[%0d] got=%0d want=%0d", a, mem[a], exp_mem[a]); end
    end
    checks++;
    if (cmp_cnt !== exp_cmps || done_cnt !== 1) begin
      fails++; $display("FAIL startcmp_counts cmp=%0d done=%0d want cmp=%0d done=1", cmp_cnt, done_cnt, exp_cmps);
    end
  endtask

  task automatic test_random();
    bit got;
    int nn;
    for (int t = 0; t < 8; t++) begin
      nn = $urandom_range(2, 9);
      for (int a = 0; a < 16; a++)
        init_mem[a] = (t % 2 == 0) ? DW'($urandom_range(0, 5)) : DW'($urandom);
      prep(nn);
      run_sort(nn, 1'b0, got);
      for (int a = 0; a < nn; a++) begin
        checks++;
        if (mem[a] !== exp_mem[a]) begin fails++; $display("FAIL random%0d_mem[%0d] got=%0d want=%0d", t, a, mem[a], exp_mem[a]); end
      end
      checks++;
      if (cmp_cnt !== exp_cmps || we_cnt !== 2 * exp_swaps) begin
        fails++; $display("FAIL random%0d_counts cmp=%0d we=%0d want cmp=%0d we=%0d", t, cmp_cnt, we_cnt, exp_cmps, 2 * exp_swaps);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_n1();
    test_sorted();
    test_equal();
    test_reset_mid();
    test_start_in_cmp();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire
